paddle_input_ctrl: RTL and testbench

- Front end for the paddle block. Converts three raw push-buttons (left, right, pause) into the clean control signals the paddle consumes: single-cycle move_left/move_right step pulses, a pause level, and a start/any-press pulse.
- Sits between the board I/O pins and the paddle position register.
- Provides synchronisation, debounce, direction arbitration, auto-repeat pacing and pause toggling.

---
 rtl/paddle_input_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_paddle_input_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/paddle_input_ctrl.sv
// rtl/paddle_input_ctrl.sv - push-button front end for the paddle: sync, debounce, direction arbitration, repeat pacing, pause
//
// Ports:
//   clk            system clock (only clock)
//   reset          asynchronous active-low reset
//   btn_left_raw   raw left button, asynchronous, active-high
//   btn_right_raw  raw right button, asynchronous, active-high
//   btn_pause_raw  raw pause button, asynchronous, active-high
//   move_left      one-cycle pulse: step paddle left
//   move_right     one-cycle pulse: step paddle right
//   pause          pause level, toggles on each debounced pause press
//   any_press      one-cycle pulse on any debounced press (game start)
//
// Optional feature macro: PADDLE_ACCEL_EN
//   When defined, after 8 repeat pulses within one MOVE state the repeat
//   interval halves to REPEAT_CYCLES>>1.

module paddle_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 100000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic btn_pause_raw,
    output logic move_left,
    output logic move_right,
    output logic pause,
    output logic any_press
);

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_P = 2;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`ifdef PADDLE_ACCEL_EN
    localparam logic [CNT_W-1:0] RPT_FAST_LAST = CNT_W'((REPEAT_CYCLES >> 1) - 1);
    localparam logic [3:0]       HOLD_SAT      = 4'd8;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MOVE_L   = 2'd1,
        MOVE_R   = 2'd2,
        CONFLICT = 2'd3
    } dir_state_t;

    logic [2:0]            raw_vec;
    logic [2:0]            sync1;
    logic [2:0]            sync2;
    logic [2:0]            stable;
    logic [2:0]            stable_d;
    logic [2:0]            rise;
    logic [2:0][CNT_W-1:0] db_cnt;

    logic                  pause_q;
    logic                  pause_d;
    logic                  any_press_q;

    dir_state_t            state;
    dir_state_t            next_state;
    logic [CNT_W-1:0]      rpt_cnt;
    logic [CNT_W-1:0]      rpt_cnt_nxt;
    logic [CNT_W-1:0]      rpt_last;
    logic                  in_move;
    logic                  state_change;
    logic                  resume;
    logic                  rpt_hit;
    logic                  fire;
    logic                  move_left_q;
    logic                  move_right_q;

`ifdef PADDLE_ACCEL_EN
    logic [3:0]            hold_cnt;
`endif

    assign raw_vec = {btn_pause_raw, btn_right_raw, btn_left_raw};

    // Two-flop synchroniser per raw button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
        end
    end

    // Debounce: the stable value only follows the synchronised input once
    // they have disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;

    // Pause toggle and start pulse; pause_d lets the pacer spot the
    // falling edge of pause and restart the cadence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pause_q     <= 1'b0;
            pause_d     <= 1'b0;
            any_press_q <= 1'b0;
        end else begin
            pause_q     <= pause_q ^ rise[BTN_P];
            pause_d     <= pause_q;
            any_press_q <= |rise;
        end
    end

    // Direction arbitration on the debounced levels.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (stable[BTN_L] && stable[BTN_R]) begin
                    next_state = CONFLICT;
                end else if (stable[BTN_L]) begin
                    next_state = MOVE_L;
                end else if (stable[BTN_R]) begin
                    next_state = MOVE_R;
                end
            end
            MOVE_L: begin
                if (stable[BTN_L] && stable[BTN_R]) begin
                    next_state = CONFLICT;
                end else if (!stable[BTN_L]) begin
                    next_state = stable[BTN_R] ? MOVE_R : IDLE;
                end
            end
            MOVE_R: begin
                if (stable[BTN_L] && stable[BTN_R]) begin
                    next_state = CONFLICT;
                end else if (!stable[BTN_R]) begin
                    next_state = stable[BTN_L] ? MOVE_L : IDLE;
                end
            end
            CONFLICT: begin
                if (!(stable[BTN_L] && stable[BTN_R])) begin
                    if (stable[BTN_L]) begin
                        next_state = MOVE_L;
                    end else if (stable[BTN_R]) begin
                        next_state = MOVE_R;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef PADDLE_ACCEL_EN
    assign rpt_last = (hold_cnt == HOLD_SAT) ? RPT_FAST_LAST : RPT_LAST;
`else
    assign rpt_last = RPT_LAST;
`endif

    // Pacing: a pulse is fired on the edge that enters a MOVE state, on the
    // edge after pause drops, and whenever the repeat counter wraps.  The
    // pulse register is loaded on the same edge as the state register, so
    // the pulse appears in the first cycle the new state is visible.
    always_comb begin
        in_move      = (next_state == MOVE_L) || (next_state == MOVE_R);
        state_change = (next_state != state);
        resume       = pause_d && !pause_q;
        rpt_hit      = (rpt_cnt == rpt_last);
        fire         = in_move && !pause_q && (state_change || resume || rpt_hit);
        rpt_cnt_nxt  = rpt_cnt + CNT_W'(1);
        if (pause_q || state_change || !in_move || fire) begin
            rpt_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rpt_cnt      <= '0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
        end else begin
            state        <= next_state;
            rpt_cnt      <= rpt_cnt_nxt;
            move_left_q  <= fire && (next_state == MOVE_L);
            move_right_q <= fire && (next_state == MOVE_R);
        end
    end

`ifdef PADDLE_ACCEL_EN
    // Counts repeat (wrap) pulses only; the entry/resume pulse is excluded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (pause_q || state_change || !in_move) begin
            hold_cnt <= '0;
        end else if (rpt_hit && !resume && hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 4'd1;
        end
    end
`endif

    // A pulse registered on the edge that turns pause on is masked so no
    // step ever coincides with pause=1.
    assign move_left  = move_left_q  && !pause_q;
    assign move_right = move_right_q && !pause_q;
    assign pause      = pause_q;
    assign any_press  = any_press_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb/tb_paddle_input_ctrl.sv - directed vector bench for paddle_input_ctrl (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)

module tb_paddle_input_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_left_raw = 1'b0;
    logic btn_right_raw = 1'b0;
    logic btn_pause_raw = 1'b0;
    logic move_left;
    logic move_right;
    logic pause;
    logic any_press;

    int checks = 0;
    int failures = 0;

    // Each record: drive {left,right,pause} for n edges; after every edge the
    // outputs {move_left,move_right,pause,any_press} must equal want.
    typedef struct {
        string      tag;
        int         n;
        logic [2:0] in;
        logic [3:0] want;
    } vec_t;

    vec_t vecs[$];

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES(8),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_left_raw(btn_left_raw),
        .btn_right_raw(btn_right_raw),
        .btn_pause_raw(btn_pause_raw),
        .move_left(move_left),
        .move_right(move_right),
        .pause(pause),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    task automatic add(input string tag, input int n, input logic [2:0] in, input logic [3:0] want);
        vec_t v;
        v.tag  = tag;
        v.n    = n;
        v.in   = in;
        v.want = want;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] want);
        checks++;
        if ({move_left, move_right, pause, any_press} !== want) begin
            failures++;
            $display("FAIL %s: got ml,mr,pause,any=%b want %b at t=%0t",
                     name, {move_left, move_right, pause, any_press}, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if (move_left && move_right) begin
            failures++;
            $display("FAIL both_moves: got move_left=1 move_right=1 want never both at t=%0t", $time);
        end
    endtask

    initial begin
        // Single press, held 30 edges: pulses 6 edges after the press, then every 8.
        add("press", 6, 3'b100, 4'b0000);
        add("press", 1, 3'b100, 4'b1001);
        add("press", 7, 3'b100, 4'b0000);
        add("press", 1, 3'b100, 4'b1000);
        add("press", 7, 3'b100, 4'b0000);
        add("press", 1, 3'b100, 4'b1000);
        add("press", 7, 3'b100, 4'b0000);
        add("press", 1, 3'b000, 4'b1000);
        add("press", 20, 3'b000, 4'b0000);
        // Bounce: 2-high/2-low never survives debounce.
        for (int i = 0; i < 5; i++) begin
            add("bounce", 2, 3'b010, 4'b0000);
            add("bounce", 2, 3'b000, 4'b0000);
        end
        add("bounce", 12, 3'b000, 4'b0000);
        // Boundary: 3-edge glitch rejected, 4-edge press accepted.
        add("glitch3", 3, 3'b010, 4'b0000);
        add("glitch3", 10, 3'b000, 4'b0000);
        add("press4", 4, 3'b010, 4'b0000);
        add("press4", 2, 3'b000, 4'b0000);
        add("press4", 1, 3'b000, 4'b0101);
        add("press4", 12, 3'b000, 4'b0000);
        // Conflict: left then both (silence), then right only.
        add("conflict", 6, 3'b100, 4'b0000);
        add("conflict", 1, 3'b100, 4'b1001);
        add("conflict", 6, 3'b110, 4'b0000);
        add("conflict", 1, 3'b110, 4'b0001);
        add("conflict", 10, 3'b110, 4'b0000);
        add("conflict", 6, 3'b010, 4'b0000);
        add("conflict", 1, 3'b010, 4'b0100);
        add("conflict", 7, 3'b010, 4'b0000);
        add("conflict", 1, 3'b010, 4'b0100);
        add("conflict", 15, 3'b000, 4'b0000);
        // Pause on, left held with no pulses, pause off resumes cadence.
        add("pause", 6, 3'b001, 4'b0000);
        add("pause", 1, 3'b000, 4'b0011);
        add("pause", 10, 3'b000, 4'b0010);
        add("pause", 6, 3'b100, 4'b0010);
        add("pause", 1, 3'b100, 4'b0011);
        add("pause", 33, 3'b100, 4'b0010);
        add("pause", 6, 3'b101, 4'b0010);
        add("pause", 1, 3'b100, 4'b0001);
        add("pause", 1, 3'b100, 4'b1000);
        add("pause", 7, 3'b100, 4'b0000);
        add("pause", 1, 3'b100, 4'b1000);
        add("pause", 12, 3'b000, 4'b0000);

        // Reset state.
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 4'b0000);
        #3;
        reset = 1'b1;

        foreach (vecs[i]) begin
            {btn_left_raw, btn_right_raw, btn_pause_raw} = vecs[i].in;
            for (int c = 0; c < vecs[i].n; c++) begin
                tick();
                check($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].want);
            end
        end

        // Long hold of right: cadence 8, or 8 then 4 after nine pulses with acceleration.
        btn_right_raw = 1'b1;
        for (int e = 1; e <= 120; e++) begin
            logic mr_want;
`ifdef PADDLE_ACCEL_EN
            mr_want = (e >= 7 && e <= 71 && ((e - 7) % 8) == 0) ||
                      (e > 71 && ((e - 71) % 4) == 0);
`else
            mr_want = (e >= 7 && ((e - 7) % 8) == 0);
`endif
            tick();
            check($sformatf("cadence_e%0d", e), {1'b0, mr_want, 1'b0, (e == 7)});
        end
        btn_right_raw = 1'b0;
        repeat (15) tick();

        // Reset asserted mid-hold, released with left still held.
        btn_left_raw = 1'b1;
        repeat (6) tick();
        tick();
        check("pre_reset_pulse", 4'b1001);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #4;
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("post_reset_e%0d", i), (i == 7) ? 4'b1001 : 4'b0000);
        end
        btn_left_raw = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
